// File: rtl/resistor_capacitor_low_pass_filter_oversampled.sv
// First-order RC low-pass filter, y += alpha*(x - y), run OVERSAMPLE times per
// audio sample with the input linearly interpolated between the previous and
// current sample. One multiply path serves every sub-step, using the idle
// clocks between audio_clk_en strobes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for audio_clk_en; out holds the last filtered value
// S_STEP | one sub-step per clock; out updates on the last sub-step
module resistor_capacitor_low_pass_filter_oversampled #(
    parameter int CLOCK_RATE   = 50000000,
    parameter int SAMPLE_RATE  = 48000,
    parameter int R            = 10000,
    parameter int C_35_SHIFTED = 344,
    parameter int OVERSAMPLE   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_audio_clk_en,
    input  logic [15:0] i_in,
    output logic [15:0] o_out,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam longint DELTA_T_32 = (64'sd1 <<< 32) / (longint'(SAMPLE_RATE) * OVERSAMPLE);
    localparam longint RC_32      = (longint'(R) * C_35_SHIFTED) >>> 3;
    localparam longint ALPHA_16   = (DELTA_T_32 <<< 16) / (RC_32 + DELTA_T_32);
    localparam int     LOG2_OS    = $clog2(OVERSAMPLE);
    localparam logic signed [17:0] ALPHA_C = 18'(ALPHA_16);
    localparam logic [5:0]         K_LAST  = 6'(OVERSAMPLE - 1);

    // Sub-steps must fit between strobes, and the interpolation relies on a shift.
    if (OVERSAMPLE < 1 || OVERSAMPLE > 64 ||
        OVERSAMPLE > CLOCK_RATE / SAMPLE_RATE - 1 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
        $error("OVERSAMPLE must be a power of two in 1..64 and below CLOCK_RATE/SAMPLE_RATE");
    end

    typedef enum logic {S_IDLE, S_STEP} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic signed [31:0] r_acc;
    logic signed [15:0] r_cur;
    logic signed [15:0] r_prev;
    logic        [5:0]  r_k;
    logic        [15:0] r_out;
    logic               r_overrun;

    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_ovr;
    logic signed [16:0] w_diff;
    logic signed [7:0]  w_kp1;
    logic signed [24:0] w_scaled;
    logic signed [17:0] w_interp;
    logic signed [17:0] w_x;
    logic signed [34:0] w_err;
    logic signed [52:0] w_prod;
    logic signed [31:0] w_acc_next;
    logic signed [16:0] w_q;
    logic        [15:0] w_sat;

    // State register; reset abandons any sub-steps in progress.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        w_ovr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_audio_clk_en) begin
                    w_load       = 1'b1;
                    w_next_state = S_STEP;
                end
            end
            S_STEP: begin
                if (i_audio_clk_en) begin
                    // A strobe while busy restarts the sweep from the new pair; acc is kept.
                    w_load = 1'b1;
                    w_ovr  = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (r_k == K_LAST) begin
                        w_last       = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Shared datapath: interpolated input, one filter update, rounded/saturated output.
    always_comb begin
        w_diff     = {r_cur[15], r_cur} - {r_prev[15], r_prev};
        w_kp1      = $signed({2'b00, r_k}) + 8'sd1;
        w_scaled   = 25'(w_diff) * 25'(w_kp1);
        w_interp   = 18'($signed({{2{r_prev[15]}}, r_prev}) + (w_scaled >>> LOG2_OS));
        w_x        = (r_k == K_LAST) ? $signed({{2{r_cur[15]}}, r_cur}) : w_interp;
        w_err      = $signed({w_x[17], w_x, 16'h0000}) - $signed({{3{r_acc[31]}}, r_acc});
        w_prod     = 53'(ALPHA_C) * 53'(w_err);
        w_acc_next = 32'(r_acc + (w_prod >>> 16));
        w_q        = 17'(($signed({w_acc_next[31], w_acc_next}) + 33'sd32768) >>> 16);
        if (w_q > 17'sd32767)       w_sat = 16'h7FFF;
        else if (w_q < -17'sd32768) w_sat = 16'h8000;
        else                        w_sat = w_q[15:0];
    end

    // Sample capture, accumulator, sub-step counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= '0;
            r_cur     <= '0;
            r_prev    <= '0;
            r_k       <= '0;
            r_out     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_ovr;
            if (w_load) begin
                r_prev <= r_cur;
                r_cur  <= $signed(i_in);
                r_k    <= '0;
            end else if (w_step) begin
                r_acc <= w_acc_next;
                r_k   <= r_k + 6'd1;
                if (w_last) r_out <= w_sat;
            end
        end
    end

    assign o_out     = r_out;
    assign o_busy    = (r_state == S_STEP);
    assign o_overrun = r_overrun;

endmodule
